// File: rtl/mnk_game_pkg.sv
// Shared encodings for the m,n,k-game: cell owners, winner codes and FSM states.
package mnk_game_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    PLAYER = 2'b01,
    COMP   = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    WIN_NONE   = 2'b00,
    WIN_PLAYER = 2'b01,
    WIN_COMP   = 2'b10,
    WIN_DRAW   = 2'b11
  } win_t;

  typedef enum logic [1:0] {
    P_TURN = 2'b00,
    C_TURN = 2'b01,
    CHECK  = 2'b10,
    DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/mnk_line_check.sv
// Run length of same-owner cells through idx along direction (DR, DC), both ways,
// clipped at the board edges so rows never wrap into each other.
module mnk_line_check
  import mnk_game_pkg::*;
#(
  parameter int N  = 3,
  parameter int DR = 0,
  parameter int DC = 1,
  localparam int unsigned IDXW = $clog2(N * N),
  localparam int unsigned BW   = $clog2(2 * N * N),
  localparam int unsigned CW   = $clog2(2 * N)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [IDXW-1:0]  idx,
  input  cell_t            owner,
  output logic [CW-1:0]    count
);

  int   r, c, rr, cc;
  logic fwd, bwd;

  function automatic logic on_board(input int row, input int col);
    return (row >= 0) && (row < N) && (col >= 0) && (col < N);
  endfunction

  always_comb begin
    r     = int'(idx) / N;
    c     = int'(idx) % N;
    rr    = 0;
    cc    = 0;
    fwd   = 1'b1;
    bwd   = 1'b1;
    count = CW'(1);
    for (int s = 1; s < N; s++) begin
      rr = r + s * DR;
      cc = c + s * DC;
      if (fwd && on_board(rr, cc) && (board[BW'(2 * (rr * N + cc)) +: 2] == owner))
        count = count + CW'(1);
      else
        fwd = 1'b0;
    end
    for (int s = 1; s < N; s++) begin
      rr = r - s * DR;
      cc = c - s * DC;
      if (bwd && on_board(rr, cc) && (board[BW'(2 * (rr * N + cc)) +: 2] == owner))
        count = count + CW'(1);
      else
        bwd = 1'b0;
    end
  end

endmodule

// File: rtl/mnk_game.sv
// m,n,k-game referee: validates moves, checks the four lines through the last move.
// Optional one-level undo enabled by defining MNK_GAME_UNDO_EN.
module mnk_game
  import mnk_game_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned CELLS = N * N,
  localparam int unsigned IDXW  = $clog2(CELLS),
  localparam int unsigned CNTW  = $clog2(CELLS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               play,
  input  logic               comp,
  input  logic [IDXW-1:0]    player,
  input  logic [IDXW-1:0]    computer,
  input  logic               restart,
`ifdef MNK_GAME_UNDO_EN
  input  logic               undo,
`endif
  output logic [2*CELLS-1:0] board,
  output logic [1:0]         winner,
  output logic               turn,
  output logic               wrong_move,
  output logic               filled,
  output logic [CNTW-1:0]    move_count
);

  localparam int unsigned CW = $clog2(2 * N);
  localparam logic [IDXW:0] CELLS_V = (IDXW + 1)'(CELLS);

  state_t            state;
  logic [IDXW-1:0]   last_idx;
  logic              mv_stb;
  logic [IDXW-1:0]   mv_idx;
  cell_t             mv_owner;
  logic              mv_legal;
  cell_t             mover;
  logic [CW-1:0]     run_row, run_col, run_dia, run_ant;
  logic              line_win;
`ifdef MNK_GAME_UNDO_EN
  logic              undo_valid;
  logic              undo_comp;
  assign undo_comp = (board[{last_idx, 1'b0} +: 2] == COMP);
`endif

  // Select the strobe/index that matters in the current turn state.
  always_comb begin
    mv_stb   = 1'b0;
    mv_idx   = player;
    mv_owner = PLAYER;
    if (state == P_TURN) begin
      mv_stb = play;
    end else if (state == C_TURN) begin
      mv_stb   = comp;
      mv_idx   = computer;
      mv_owner = COMP;
    end
  end

  assign mv_legal = ({1'b0, mv_idx} < CELLS_V) && (board[{mv_idx, 1'b0} +: 2] == EMPTY);
  assign mover    = turn ? COMP : PLAYER;
  assign filled   = (move_count == CNTW'(CELLS));

  mnk_line_check #(.N(N), .DR(0), .DC(1))  u_row (.board(board), .idx(last_idx), .owner(mover), .count(run_row));
  mnk_line_check #(.N(N), .DR(1), .DC(0))  u_col (.board(board), .idx(last_idx), .owner(mover), .count(run_col));
  mnk_line_check #(.N(N), .DR(1), .DC(1))  u_dia (.board(board), .idx(last_idx), .owner(mover), .count(run_dia));
  mnk_line_check #(.N(N), .DR(1), .DC(-1)) u_ant (.board(board), .idx(last_idx), .owner(mover), .count(run_ant));

  assign line_win = (run_row >= CW'(K)) || (run_col >= CW'(K)) ||
                    (run_dia >= CW'(K)) || (run_ant >= CW'(K));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= P_TURN;
      board      <= '0;
      winner     <= WIN_NONE;
      turn       <= 1'b0;
      wrong_move <= 1'b0;
      move_count <= '0;
      last_idx   <= '0;
`ifdef MNK_GAME_UNDO_EN
      undo_valid <= 1'b0;
`endif
    end else begin
      wrong_move <= 1'b0;
      if (restart) begin
        state      <= P_TURN;
        board      <= '0;
        winner     <= WIN_NONE;
        turn       <= 1'b0;
        move_count <= '0;
        last_idx   <= '0;
`ifdef MNK_GAME_UNDO_EN
        undo_valid <= 1'b0;
`endif
      end else begin
        case (state)
          P_TURN, C_TURN: begin
`ifdef MNK_GAME_UNDO_EN
            if (undo && undo_valid) begin
              board[{last_idx, 1'b0} +: 2] <= EMPTY;
              move_count <= move_count - CNTW'(1);
              turn       <= undo_comp;
              state      <= undo_comp ? C_TURN : P_TURN;
              undo_valid <= 1'b0;
            end else
`endif
            if (mv_stb) begin
              if (mv_legal) begin
                board[{mv_idx, 1'b0} +: 2] <= mv_owner;
                move_count <= move_count + CNTW'(1);
                last_idx   <= mv_idx;
                state      <= CHECK;
`ifdef MNK_GAME_UNDO_EN
                undo_valid <= 1'b1;
`endif
              end else begin
                wrong_move <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (line_win) begin
              winner <= turn ? WIN_COMP : WIN_PLAYER;
              state  <= DONE;
            end else if (filled) begin
              winner <= WIN_DRAW;
              state  <= DONE;
            end else begin
              turn  <= ~turn;
              state <= turn ? P_TURN : C_TURN;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
